// File: rtl/kernel_ctrl_axil_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kernel_ctrl_axil_master_if                                               |
// | AXI4-Lite bundle between the launch master and the kernel control slave. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface kernel_ctrl_axil_master_if #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic                      rvalid;
  logic                      rready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/kernel_ctrl_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kernel_ctrl_axil_master                                                  |
// | Programs kernel buffer pointers over AXI4-Lite, starts the kernel and    |
// | waits for completion. Define KERNEL_CTRL_IRQ_EN for interrupt-driven     |
// | completion instead of AP_CTRL polling.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kernel_ctrl_axil_master #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_POLL_GAP   = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        aclk_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_ptr0,
  input  logic [63:0] cmd_ptr1,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] poll_count,
  input  logic        interrupt,
  kernel_ctrl_axil_master_if.master m
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_REQ   = 3'd1,
    S_WR_RESP  = 3'd2,
    S_RD_REQ   = 3'd3,
    S_RD_DATA  = 3'd4,
    S_GAP      = 3'd5,
    S_WAIT_IRQ = 3'd6,
    S_DONE     = 3'd7
  } state_t;

`ifdef KERNEL_CTRL_IRQ_EN
  localparam logic [2:0] PTR_FIRST  = 3'd2;
  localparam logic [2:0] START_STEP = 3'd6;
  localparam logic [2:0] ISR_STEP   = 3'd7;
`else
  localparam logic [2:0] PTR_FIRST  = 3'd0;
  localparam logic [2:0] START_STEP = 3'd4;
`endif
  localparam logic [C_ADDR_WIDTH-1:0] AP_CTRL_ADDR = '0;

  state_t      state;
  logic [2:0]  step;
  logic [63:0] ptr0_q;
  logic [63:0] ptr1_q;
  logic [15:0] gap_cnt;
  logic        unused_bits;

  // Step sequence: [GIE, IER,] ptr0 lo/hi, ptr1 lo/hi, AP_START [, ISR]
  function automatic logic [C_ADDR_WIDTH-1:0] step_addr(input logic [2:0] idx);
    logic [11:0] a;
    case (idx)
`ifdef KERNEL_CTRL_IRQ_EN
      3'd0:    a = 12'h004;
      3'd1:    a = 12'h008;
      3'd2:    a = 12'h010;
      3'd3:    a = 12'h014;
      3'd4:    a = 12'h018;
      3'd5:    a = 12'h01C;
      3'd6:    a = 12'h000;
      default: a = 12'h00C;
`else
      3'd0:    a = 12'h010;
      3'd1:    a = 12'h014;
      3'd2:    a = 12'h018;
      3'd3:    a = 12'h01C;
      default: a = 12'h000;
`endif
    endcase
    return C_ADDR_WIDTH'(a);
  endfunction

  function automatic logic [C_DATA_WIDTH-1:0] step_data(input logic [2:0] idx,
                                                        input logic [63:0] p0,
                                                        input logic [63:0] p1);
    logic [2:0]  rel;
    logic [31:0] d;
    rel = idx - PTR_FIRST;
    case (rel)
      3'd0:    d = p0[31:0];
      3'd1:    d = p0[63:32];
      3'd2:    d = p1[31:0];
      3'd3:    d = p1[63:32];
      default: d = 32'h1;
    endcase
    return C_DATA_WIDTH'(d);
  endfunction

  assign m.wstrb  = '1;
  assign m.araddr = AP_CTRL_ADDR;
  assign unused_bits = &{1'b0, interrupt, m.rdata};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      step       <= '0;
      ptr0_q     <= '0;
      ptr1_q     <= '0;
      gap_cnt    <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      poll_count <= '0;
      m.awvalid  <= 1'b0;
      m.awaddr   <= '0;
      m.wvalid   <= 1'b0;
      m.wdata    <= '0;
      m.bready   <= 1'b0;
      m.arvalid  <= 1'b0;
      m.rready   <= 1'b0;
    end else if (aclk_en) begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ptr0_q     <= cmd_ptr0;
            ptr1_q     <= cmd_ptr1;
            err        <= 1'b0;
            poll_count <= '0;
            busy       <= 1'b1;
            cmd_ready  <= 1'b0;
            step       <= 3'd0;
            m.awaddr   <= step_addr(3'd0);
            m.wdata    <= step_data(3'd0, cmd_ptr0, cmd_ptr1);
            m.awvalid  <= 1'b1;
            m.wvalid   <= 1'b1;
            state      <= S_WR_REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_WR_REQ: begin
          if (m.awready) m.awvalid <= 1'b0;
          if (m.wready)  m.wvalid  <= 1'b0;
          // Response is only accepted once both address and data have been taken.
          if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
            m.bready <= 1'b1;
            state    <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m.bvalid) begin
            m.bready <= 1'b0;
            if (m.bresp != 2'b00) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (step == START_STEP) begin
`ifdef KERNEL_CTRL_IRQ_EN
              state <= S_WAIT_IRQ;
`else
              m.arvalid <= 1'b1;
              state     <= S_RD_REQ;
`endif
            end
`ifdef KERNEL_CTRL_IRQ_EN
            else if (step == ISR_STEP) begin
              m.arvalid <= 1'b1;
              state     <= S_RD_REQ;
            end
`endif
            else begin
              step      <= step + 3'd1;
              m.awaddr  <= step_addr(step + 3'd1);
              m.wdata   <= step_data(step + 3'd1, ptr0_q, ptr1_q);
              m.awvalid <= 1'b1;
              m.wvalid  <= 1'b1;
              state     <= S_WR_REQ;
            end
          end
        end

        S_WAIT_IRQ: begin
`ifdef KERNEL_CTRL_IRQ_EN
          if (interrupt) begin
            step      <= ISR_STEP;
            m.awaddr  <= step_addr(ISR_STEP);
            m.wdata   <= step_data(ISR_STEP, ptr0_q, ptr1_q);
            m.awvalid <= 1'b1;
            m.wvalid  <= 1'b1;
            state     <= S_WR_REQ;
          end
`else
          state <= S_IDLE;
`endif
        end

        S_RD_REQ: begin
          if (m.arready) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (m.rvalid) begin
            m.rready <= 1'b0;
            if (poll_count != 16'hFFFF) poll_count <= poll_count + 16'd1;
            if (m.rresp != 2'b00) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
`ifdef KERNEL_CTRL_IRQ_EN
            else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
`else
            else if (m.rdata[1]) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
`endif
          end
        end

        S_GAP: begin
          if (gap_cnt == 16'(C_POLL_GAP - 1)) begin
            m.arvalid <= 1'b1;
            state     <= S_RD_REQ;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kernel_ctrl_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_kernel_ctrl_axil_master                                               |
// | Self-checking bench: reactive AXI4-Lite slave plus launch-level model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_kernel_ctrl_axil_master;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int GAP = 6;

  logic        aclk = 1'b0;
  logic        areset;
  logic        aclk_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_ptr0;
  logic [63:0] cmd_ptr1;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] poll_count;
  logic        interrupt;

  kernel_ctrl_axil_master_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) m_if ();

  kernel_ctrl_axil_master #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_POLL_GAP(GAP)) dut (
    .aclk(aclk), .areset(areset), .aclk_en(aclk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ptr0(cmd_ptr0), .cmd_ptr1(cmd_ptr1),
    .busy(busy), .done(done), .err(err), .poll_count(poll_count),
    .interrupt(interrupt), .m(m_if)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Slave configuration, set by the directed sequence before each launch
  int          aw_delay, w_delay, b_delay, ar_delay, r_delay, done_at;
  logic [11:0] err_addr;

  // Slave state and observations
  int          cyc = 0;
  bit          aw_got, w_got, b_pend, ar_got;
  logic [11:0] aw_addr_c;
  logic [31:0] w_data_c, rdata_c;
  logic [1:0]  bresp_c;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, irq_cd;
  int          reads_in_run, done_pulses;
  bit          p_en, p_rst, p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr, p_done;
  logic [11:0] p_awaddr;
  logic [31:0] p_wdata;
  logic [43:0] wr_q[$];
  logic [43:0] exp_q[$];
  int          ar_times[$];
  bit          exp_err;
  int          exp_poll;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reactive slave: evaluates just after each falling edge, so everything it
  // sees was presented to the following rising edge.
  initial begin
    {aw_got, w_got, b_pend, ar_got} = '0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, irq_cd} = '0;
    interrupt = 1'b0;
    {m_if.awready, m_if.wready, m_if.bvalid, m_if.arready, m_if.rvalid} = '0;
    m_if.bresp = 2'b00; m_if.rresp = 2'b00; m_if.rdata = '0;
    {p_en, p_rst, p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr, p_done} = '0;
    p_awaddr = '0; p_wdata = '0; bresp_c = 2'b00; rdata_c = '0;
    forever begin
      @(negedge aclk);
      #1;
      cyc++;
      if (p_rst) begin
        {aw_got, w_got, b_pend, ar_got} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, irq_cd} = '0;
        interrupt = 1'b0;
      end else begin
        if (p_awv && !(p_awr && p_en)) begin
          check("aw_hold", {m_if.awvalid, m_if.awaddr}, {1'b1, p_awaddr});
        end
        if (p_wv && !(p_wr && p_en)) begin
          check("w_hold", {m_if.wvalid, m_if.wdata}, {1'b1, p_wdata});
        end
        if (p_en) begin
          if (p_awv && p_awr) begin
            check("aw_duplicate", aw_got, 1'b0);
            aw_got = 1'b1; aw_addr_c = p_awaddr;
          end
          if (p_wv && p_wr) begin w_got = 1'b1; w_data_c = p_wdata; end
          if (p_bv && p_br) begin b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
          if (p_arv && p_arr) begin
            ar_got = 1'b1; r_cnt = 0; reads_in_run++;
            ar_times.push_back(cyc);
            rdata_c = $urandom();
            rdata_c[1] = (reads_in_run >= done_at);
          end
          if (p_rv && p_rr) ar_got = 1'b0;
          if (p_done) done_pulses++;
        end
        if (aw_got && w_got && !b_pend) begin
          wr_q.push_back({aw_addr_c, w_data_c});
          check("wstrb", m_if.wstrb, 4'hF);
          b_pend = 1'b1; b_cnt = 0;
          bresp_c = (aw_addr_c == err_addr) ? 2'b10 : 2'b00;
          if (aw_addr_c == 12'h000 && w_data_c == 32'h1) irq_cd = 50;
          if (aw_addr_c == 12'h00C) interrupt = 1'b0;
        end
        if (m_if.bready) check("bready_early", aw_got && w_got, 1'b1);
      end
      if (m_if.awvalid && !aw_got) aw_cnt++; else aw_cnt = 0;
      if (m_if.wvalid && !w_got) w_cnt++; else w_cnt = 0;
      if (m_if.arvalid && !ar_got) ar_cnt++; else ar_cnt = 0;
      if (b_pend) b_cnt++;
      if (ar_got) r_cnt++;
      if (irq_cd > 0) begin irq_cd--; if (irq_cd == 0) interrupt = 1'b1; end
      m_if.awready = m_if.awvalid && !aw_got && (aw_cnt > aw_delay);
      m_if.wready  = m_if.wvalid && !w_got && (w_cnt > w_delay);
      m_if.bvalid  = b_pend && (b_cnt > b_delay);
      m_if.bresp   = b_pend ? bresp_c : 2'b00;
      m_if.arready = m_if.arvalid && !ar_got && (ar_cnt > ar_delay);
      m_if.rvalid  = ar_got && (r_cnt > r_delay);
      m_if.rdata   = ar_got ? rdata_c : '0;
      m_if.rresp   = 2'b00;
      p_en = aclk_en; p_rst = areset; p_done = done;
      p_awv = m_if.awvalid; p_awr = m_if.awready; p_awaddr = m_if.awaddr;
      p_wv = m_if.wvalid; p_wr = m_if.wready; p_wdata = m_if.wdata;
      p_bv = m_if.bvalid; p_br = m_if.bready;
      p_arv = m_if.arvalid; p_arr = m_if.arready;
      p_rv = m_if.rvalid; p_rr = m_if.rready;
    end
  end

  // Launch-level model: register writes the kernel should see, in order.
  task automatic build_expected(input logic [63:0] p0, input logic [63:0] p1);
    int cut;
    exp_q.delete();
`ifdef KERNEL_CTRL_IRQ_EN
    exp_q.push_back({12'h004, 32'h1});
    exp_q.push_back({12'h008, 32'h1});
`endif
    exp_q.push_back({12'h010, p0[31:0]});
    exp_q.push_back({12'h014, p0[63:32]});
    exp_q.push_back({12'h018, p1[31:0]});
    exp_q.push_back({12'h01C, p1[63:32]});
    exp_q.push_back({12'h000, 32'h1});
`ifdef KERNEL_CTRL_IRQ_EN
    exp_q.push_back({12'h00C, 32'h1});
`endif
    cut = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (cut < 0 && exp_q[i][43:32] == err_addr) cut = i;
    exp_err = (cut >= 0);
    if (exp_err) while (exp_q.size() > cut + 1) void'(exp_q.pop_back());
`ifdef KERNEL_CTRL_IRQ_EN
    exp_poll = exp_err ? 0 : 1;
`else
    exp_poll = exp_err ? 0 : done_at;
`endif
  endtask

  task automatic start_cmd(input string tag, input logic [63:0] p0, input logic [63:0] p1);
    int n;
    build_expected(p0, p1);
    wr_q.delete(); ar_times.delete(); reads_in_run = 0; done_pulses = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_ptr0 = p0; cmd_ptr1 = p1; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check({tag, "_busy_on_accept"}, {busy, cmd_ready, m_if.awvalid}, 3'b101);
  endtask

  task automatic finish_cmd(input string tag);
    int n;
    n = 0;
    while (done_pulses == 0 && n < 3000) begin @(negedge aclk); n++; end
    check({tag, "_done_timeout"}, (n < 3000), 1'b1);
    repeat (GAP + 4) @(negedge aclk);
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    check({tag, "_done_pulses"}, done_pulses, 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_poll_count"}, poll_count, exp_poll);
    check({tag, "_idle"}, {busy, cmd_ready, done}, 3'b010);
    for (int i = 1; i < ar_times.size(); i++)
      check($sformatf("%s_ar_gap%0d", tag, i), (ar_times[i] - ar_times[i-1] >= GAP), 1'b1);
  endtask

  task automatic zero_delays();
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
  endtask

  initial begin
    logic [63:0] snap;
    logic [63:0] rp0, rp1;
    int n;
    areset = 1'b1; aclk_en = 1'b1; cmd_valid = 1'b0; cmd_ptr0 = '0; cmd_ptr1 = '0;
    zero_delays(); done_at = 1; err_addr = 12'hFFF;
    repeat (3) @(negedge aclk);
    check("rst_bus", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 5'b0);
    check("rst_status", {cmd_ready, busy, done, err}, 4'b0);
    check("rst_poll_count", poll_count, 16'h0);
    areset = 1'b0;
    @(negedge aclk);
    check("cmd_ready_first_cycle", cmd_ready, 1'b1);

    start_cmd("basic", 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD);
    finish_cmd("basic");

    done_at = 4;
    start_cmd("poll4", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    finish_cmd("poll4");

    done_at = 1; w_delay = 5;
    start_cmd("wdelay", 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002);
    finish_cmd("wdelay");
    zero_delays();

    err_addr = 12'h014;
    start_cmd("bresp_err", 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC);
    finish_cmd("bresp_err");
    err_addr = 12'hFFF;
    start_cmd("err_clear", 64'h1, 64'h2);
    finish_cmd("err_clear");

    done_at = 3;
    start_cmd("mid_reset", 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
    n = 0;
    while (!m_if.rready && n < 2000) begin @(negedge aclk); n++; end
    check("mid_reset_reach_rd_data", m_if.rready, 1'b1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("mid_reset_bus", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 5'b0);
    check("mid_reset_busy", {busy, done}, 2'b0);
    done_at = 2;
    start_cmd("after_reset", 64'h0F0F_0F0F_F0F0_F0F0, 64'h3C3C_3C3C_C3C3_C3C3);
    finish_cmd("after_reset");

    w_delay = 2; b_delay = 1; done_at = 2;
    start_cmd("freeze", 64'h2468_ACE0_1357_9BDF, 64'h1122_3344_5566_7788);
    repeat (2) @(negedge aclk);
    snap = {14'd0, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready, busy,
            m_if.awaddr, m_if.wdata};
    aclk_en = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      check("freeze_hold", {14'd0, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid,
                            m_if.rready, busy, m_if.awaddr, m_if.wdata}, snap);
    end
    aclk_en = 1'b1;
    finish_cmd("freeze");

    for (int k = 0; k < 6; k++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3); done_at  = $urandom_range(1, 5);
      err_addr = (k == 3) ? 12'h018 : 12'hFFF;
      rp0 = {$urandom(), $urandom()};
      rp1 = {$urandom(), $urandom()};
      start_cmd($sformatf("rand%0d", k), rp0, rp1);
      finish_cmd($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
